// File: rtl/sw_rx.sv
// sw_rx: egress receiver for one `sw` switch port; frames, buffers and releases whole packets.
// Optional destination check enabled by defining SW_RX_DEST_CHK_EN.
module sw_rx #(
  parameter int PKTW  = 9,
  parameter int DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PKTW:0]   in,
  input  logic [1:0]      port_id,
  output logic [PKTW-2:0] out_data,
  output logic            out_sop,
  output logic            out_eop,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            err_frame,
  output logic            err_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] ONE_P   = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  localparam logic [1:0] T_HDR = 2'b10;
  localparam logic [1:0] T_PAY = 2'b01;
  localparam logic [1:0] T_TRL = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RECV = 2'b01,
    S_DROP = 2'b10
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_commit_ptr;
  logic [PKTW:0]   r_mem [DEPTH];
  logic            r_err_frame;
  logic            r_err_ovf;

  logic [1:0]      w_type;
  logic [PKTW-2:0] w_data;
  logic [PKTW:0]   w_entry;
  logic [PKTW:0]   w_rd_entry;
  logic [PW-1:0]   w_used_all;
  logic [PW-1:0]   w_used_cmt;
  logic            w_full_all;
  logic            w_full_cmt;
  logic            w_misroute;
  logic            w_hdr_ok;
  logic            w_rd_fire;
  logic            w_we;
  logic [PW-1:0]   w_wr_addr;
  logic [PW-1:0]   w_wr_ptr_nxt;
  logic [PW-1:0]   w_commit_nxt;
  logic            w_err_frame;
  logic            w_err_ovf;

  assign w_type  = in[PKTW:PKTW-1];
  assign w_data  = in[PKTW-2:0];
  assign w_entry = {(w_type == T_HDR), (w_type == T_TRL), w_data};

  // Space is judged with the pre-edge read pointer, so a same-cycle read never frees room.
  assign w_used_all = r_wr_ptr - r_rd_ptr;
  assign w_used_cmt = r_commit_ptr - r_rd_ptr;
  assign w_full_all = (w_used_all == DEPTH_P);
  assign w_full_cmt = (w_used_cmt == DEPTH_P);

`ifdef SW_RX_DEST_CHK_EN
  assign w_misroute = (w_data[1:0] != port_id);
`else
  logic w_unused_port_id;
  assign w_unused_port_id = ^port_id;
  assign w_misroute       = 1'b0;
`endif

  // A header always lands at commit_ptr: any partial packet is discarded before it.
  assign w_hdr_ok = !w_misroute && !w_full_cmt;

  assign w_rd_fire  = out_valid && out_ready;
  assign w_rd_entry = r_mem[r_rd_ptr[AW-1:0]];
  assign out_valid  = (r_rd_ptr != r_commit_ptr);
  assign out_data   = out_valid ? w_rd_entry[PKTW-2:0] : {(PKTW-1){1'b0}};
  assign out_sop    = out_valid & w_rd_entry[PKTW];
  assign out_eop    = out_valid & w_rd_entry[PKTW-1];
  assign err_frame  = r_err_frame;
  assign err_ovf    = r_err_ovf;

  // Framing FSM: next state, buffer write and rollback decisions for the sampled flit.
  always_comb begin
    w_next_state = r_state;
    w_we         = 1'b0;
    w_wr_addr    = r_wr_ptr;
    w_wr_ptr_nxt = r_wr_ptr;
    w_commit_nxt = r_commit_ptr;
    w_err_frame  = 1'b0;
    w_err_ovf    = 1'b0;
    case (r_state)
      S_IDLE, S_DROP: begin
        case (w_type)
          T_HDR: begin
            w_err_frame  = w_misroute;
            w_err_ovf    = !w_misroute && w_full_cmt;
            w_we         = w_hdr_ok;
            w_wr_addr    = r_commit_ptr;
            w_wr_ptr_nxt = w_hdr_ok ? (r_commit_ptr + ONE_P) : r_commit_ptr;
            w_next_state = w_hdr_ok ? S_RECV : S_DROP;
          end
          T_PAY: begin
            w_err_frame = (r_state == S_IDLE);
          end
          T_TRL: begin
            w_err_frame  = (r_state == S_IDLE);
            w_next_state = S_IDLE;
          end
          default: begin
            w_next_state = r_state;
          end
        endcase
      end
      S_RECV: begin
        case (w_type)
          T_HDR: begin
            w_err_frame  = 1'b1;
            w_err_ovf    = !w_misroute && w_full_cmt;
            w_we         = w_hdr_ok;
            w_wr_addr    = r_commit_ptr;
            w_wr_ptr_nxt = w_hdr_ok ? (r_commit_ptr + ONE_P) : r_commit_ptr;
            w_next_state = w_hdr_ok ? S_RECV : S_DROP;
          end
          T_PAY: begin
            if (w_full_all) begin
              w_err_ovf    = 1'b1;
              w_wr_ptr_nxt = r_commit_ptr;
              w_next_state = S_DROP;
            end else begin
              w_we         = 1'b1;
              w_wr_ptr_nxt = r_wr_ptr + ONE_P;
            end
          end
          T_TRL: begin
            w_next_state = S_IDLE;
            if (w_full_all) begin
              w_err_ovf    = 1'b1;
              w_wr_ptr_nxt = r_commit_ptr;
            end else begin
              w_we         = 1'b1;
              w_wr_ptr_nxt = r_wr_ptr + ONE_P;
              w_commit_nxt = r_wr_ptr + ONE_P;
            end
          end
          default: begin
            w_next_state = S_RECV;
          end
        endcase
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Buffer pointers and registered error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr     <= {PW{1'b0}};
      r_wr_ptr     <= {PW{1'b0}};
      r_commit_ptr <= {PW{1'b0}};
      r_err_frame  <= 1'b0;
      r_err_ovf    <= 1'b0;
    end else begin
      r_rd_ptr     <= w_rd_fire ? (r_rd_ptr + ONE_P) : r_rd_ptr;
      r_wr_ptr     <= w_wr_ptr_nxt;
      r_commit_ptr <= w_commit_nxt;
      r_err_frame  <= w_err_frame;
      r_err_ovf    <= w_err_ovf;
    end
  end

  // Packet storage; contents are meaningful only between rd_ptr and wr_ptr.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_wr_addr[AW-1:0]] <= w_entry;
    end
  end

endmodule

// File: tb/tb_sw_rx.sv
// tb_sw_rx: directed and random stimulus for sw_rx, checked each cycle against a packet-queue model.
module tb_sw_rx;
  localparam int PKTW  = 9;
  localparam int DEPTH = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [PKTW:0]   in_s;
  logic [1:0]      port_id;
  logic [PKTW-2:0] out_data;
  logic            out_sop, out_eop, out_valid, out_ready;
  logic            err_frame, err_ovf;

  always #5 clk = ~clk;

  sw_rx #(.PKTW(PKTW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in(in_s), .port_id(port_id),
    .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
    .out_valid(out_valid), .out_ready(out_ready),
    .err_frame(err_frame), .err_ovf(err_ovf)
  );

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic [7:0] data;
  } ent_t;

  // Model: committed-but-unread entries, the packet in progress, and framing mode.
  ent_t q[$];
  ent_t part[$];
  bit   in_pkt, dropping;
  bit   exp_ferr, exp_oerr;
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit misroute(input logic [9:0] f);
`ifdef SW_RX_DEST_CHK_EN
    return f[1:0] != port_id;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_clear();
    q.delete(); part.delete();
    in_pkt = 0; dropping = 0; exp_ferr = 0; exp_oerr = 0;
  endtask

  // Apply one rising edge to the model; space is counted before any same-edge read.
  task automatic model_edge(input logic [9:0] f, input logic rdy);
    bit   pop;
    ent_t e;
    pop = (q.size() != 0) && rdy;
    exp_ferr = 0; exp_oerr = 0;
    e = {f[9:8] == 2'b10, f[9:8] == 2'b11, f[7:0]};
    case (f[9:8])
      2'b10: begin
        if (in_pkt) begin exp_ferr = 1; part.delete(); end
        if (misroute(f)) begin
          exp_ferr = 1; in_pkt = 0; dropping = 1;
        end else if (q.size() + part.size() >= DEPTH) begin
          exp_oerr = 1; in_pkt = 0; dropping = 1;
        end else begin
          part.push_back(e); in_pkt = 1; dropping = 0;
        end
      end
      2'b01: begin
        if (in_pkt) begin
          if (q.size() + part.size() >= DEPTH) begin
            exp_oerr = 1; part.delete(); in_pkt = 0; dropping = 1;
          end else part.push_back(e);
        end else if (!dropping) exp_ferr = 1;
      end
      2'b11: begin
        if (in_pkt) begin
          if (q.size() + part.size() >= DEPTH) exp_oerr = 1;
          else begin
            part.push_back(e);
            foreach (part[i]) q.push_back(part[i]);
          end
          part.delete(); in_pkt = 0;
        end else if (!dropping) exp_ferr = 1;
        dropping = 0;
      end
      default: ;
    endcase
    if (pop) void'(q.pop_front());
  endtask

  task automatic check_outputs();
    check("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      check("out_data", out_data, q[0].data);
      check("out_sop", out_sop, q[0].sop);
      check("out_eop", out_eop, q[0].eop);
    end else if (part.size() == 0) begin
      check("empty_data", out_data, 0);
      check("empty_sop_eop", {out_sop, out_eop}, 0);
    end
    check("err_frame", err_frame, exp_ferr);
    check("err_ovf", err_ovf, exp_oerr);
  endtask

  // Called at a negative edge: drive, clock, update model, check.
  task automatic step(input logic [9:0] f, input logic rdy);
    in_s = f; out_ready = rdy;
    @(posedge clk);
    model_edge(f, rdy);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic send_pkt(input logic [7:0] d, input int npay, input logic rdy);
    step({2'b10, d}, rdy);
    for (int i = 0; i < npay; i++) step({2'b01, 8'(d + i + 1)}, rdy);
    step({2'b11, 8'(d + 8'hF0)}, rdy);
  endtask

  // Drain with out_ready high, counting handshakes seen on the DUT.
  task automatic drain(input string tag, input int exp_cnt);
    int cnt = 0;
    for (int g = 0; g < 64 && out_valid; g++) begin
      cnt++;
      step(10'b00_0000_0000, 1'b1);
    end
    check(tag, cnt, exp_cnt);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_s = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
    check("rst_valid", out_valid, 0);
    check("rst_errs", {err_frame, err_ovf}, 0);
    check_outputs();
  endtask

  initial begin
    int   ovf_cnt, ferr_cnt, vld_cnt;
    logic [9:0] f;
    port_id = 2'd0;
    do_reset();

    // Basic 4-flit packet
    step(10'b10_0000_0000, 1'b1);
    step(10'b01_0000_0000, 1'b1);
    step(10'b01_0000_0001, 1'b1);
    check("t1_no_early_valid", out_valid, 0);
    step(10'b11_0000_0010, 1'b1);
    check("t1_first_valid", out_valid, 1);
    check("t1_first_sop", {out_sop, out_data}, 9'h100);
    drain("t1_drain", 4);

    // Back-to-back short packets held, then drained
    for (int i = 0; i < 4; i++) begin
      step(10'b10_0001_0000, 1'b0);
      step(10'b11_0001_1111, 1'b0);
    end
    drain("t2_drain", 8);

    // Framing errors
    step(10'b01_0000_0001, 1'b0);
    check("t3_stray_payload", err_frame, 1);
    check("t3_nothing_stored", out_valid, 0);
    ferr_cnt = 0;
    step(10'b10_0000_0000, 1'b0); ferr_cnt += err_frame;
    step(10'b01_0000_0011, 1'b0); ferr_cnt += err_frame;
    step(10'b10_1001_0000, 1'b0); ferr_cnt += err_frame;
    step(10'b11_1001_0001, 1'b0); ferr_cnt += err_frame;
    check("t3_ferr_once", ferr_cnt, 1);
    drain("t3_drain", 2);

    // Overflow: 20-flit packet into an empty 16-entry buffer
    ovf_cnt = 0; vld_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      f = (i == 0) ? 10'h200 : (i == 19) ? 10'h3FF : {2'b01, 8'(i)};
      step(f, 1'b0);
      if (i == 16) check("t4_ovf_17th", err_ovf, 1);
      ovf_cnt += err_ovf; vld_cnt += out_valid;
    end
    check("t4_ovf_once", ovf_cnt, 1);
    check("t4_never_valid", vld_cnt, 0);
    send_pkt(8'h5A, 0, 1'b0);
    drain("t4_drain", 2);

    // 15 committed entries; trailer's free ignores its own-cycle read
    for (int i = 0; i < 5; i++) send_pkt(8'(i * 16), 1, 1'b0);
    step(10'b10_0110_0000, 1'b0);
    check("t5_hdr_no_ovf", err_ovf, 0);
    step(10'b11_0110_0001, 1'b1);
    check("t5_trl_ovf", err_ovf, 1);
    drain("t5_drain", 14);

    // Reset mid-packet discards committed and partial data
    send_pkt(8'h11, 2, 1'b0);
    step(10'b10_0010_0010, 1'b0);
    step(10'b01_0010_0011, 1'b0);
    do_reset();

`ifdef SW_RX_DEST_CHK_EN
    port_id = 2'd1;
    do_reset();
    step(10'b10_0000_0000, 1'b0);
    check("t6_misroute", err_frame, 1);
    step(10'b11_0000_0000, 1'b0);
    step(10'b10_0000_0001, 1'b0);
    step(10'b11_0000_0001, 1'b0);
    drain("t6_drain", 2);
`endif

    // Random traffic with varying consumer pressure
    for (int ph = 0; ph < 6; ph++) begin
      for (int c = 0; c < 400; c++) begin
        int r;
        r = $urandom_range(0, 9);
        f[9:8] = (r < 2) ? 2'b00 : (r < 3) ? 2'b10 : (r < 8) ? 2'b01 : 2'b11;
        f[7:0] = 8'($urandom);
        step(f, ($urandom_range(0, 5) < ph) ? 1'b1 : 1'b0);
      end
    end
    drain("rand_drain_end", q.size());

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/sw_rx.md
Name: sw_rx

Overview:
- Egress receiver attached to one output port of the 4-way `sw` switch; consumes the 10-bit flit stream the switch emits.
- Validates packet framing (header / payload / trailer).
- Buffers packets store-and-forward and releases only complete, well-formed packets to a downstream consumer over a valid/ready interface.
- Malformed or overflowing packets are rolled back and never become visible downstream.

Parameters:
- PKTW, 9, MSB index of a flit (flit = PKTW+1 bits; [PKTW:PKTW-1] type, [PKTW-2:0] data).
- DEPTH, 16, buffer entries (power of two, >= 2); one entry per stored flit.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in  input  PKTW+1  flit from switch output; type 2'b00 empty, 2'b10 header, 2'b01 payload, 2'b11 trailer.
- port_id  input  2  this receiver's switch port number; static after reset.
- out_data  output  PKTW-1  data byte of the stored flit at the read pointer.
- out_sop  output  1  current entry is a header.
- out_eop  output  1  current entry is a trailer.
- out_valid  output  1  a committed entry is available.
- out_ready  input  1  consumer accepts the entry when out_valid && out_ready.
- err_frame  output  1  one-cycle pulse on a framing error.
- err_ovf  output  1  one-cycle pulse on buffer overflow drop.

Behaviour:
- Reset (async):
  - rd_ptr, wr_ptr and commit_ptr = 0 (log2(DEPTH)+1 bits, wrap by natural overflow).
  - State IDLE.
  - out_valid = 0; err_frame = 0; err_ovf = 0.
  - out_data, out_sop and out_eop are don't-care, but driven to 0 while the buffer is empty.
- Entry format: {sop, eop, data}.
  - Header stored as sop=1.
  - Trailer stored as eop=1.
  - Payload stored with both 0.
  - Empty flits are never stored.
- Write space:
  - free = DEPTH - (wr_ptr - rd_ptr), evaluated with the pre-edge rd_ptr.
  - A read in the same cycle does not free space for that cycle's write.
- FSM, input sampled every rising edge:
  - IDLE:
    - header: write it, go RECV.
    - payload/trailer: err_frame pulse, discard, stay IDLE.
    - empty: stay.
  - RECV:
    - payload: write.
    - trailer: write, commit_ptr <= wr_ptr+1, go IDLE.
    - empty: bubble, ignored, stay RECV.
    - header: err_frame pulse, wr_ptr <= commit_ptr (rollback), then write the new header at commit_ptr, stay RECV.
  - DROP:
    - payload/empty: discard.
    - trailer: go IDLE.
    - header: start a new packet as in IDLE.
- Overflow:
  - Any write attempted in IDLE or RECV with free == 0 triggers a rollback: wr_ptr <= commit_ptr.
  - err_ovf pulses; flit discarded.
  - Next state: IDLE if the flit was a trailer, otherwise DROP.
  - A packet longer than DEPTH flits is always dropped.
- Output:
  - out_valid = (rd_ptr != commit_ptr).
  - out_* read combinationally from the array at rd_ptr.
  - Handshake increments rd_ptr.
  - out_valid may not depend on out_ready.
- Latency: trailer sampled at edge N; header appears with out_valid=1 immediately after edge N. One cycle minimum from trailer on `in` to visible output.
- Back-to-back flits (header in the cycle right after a trailer) are accepted without loss.
- Partially received packets are never visible: out_valid covers only committed entries.
- Reset mid-packet discards everything, including committed but unread entries.

Optional Feature:
- Macro: SW_RX_DEST_CHK_EN.
- When defined:
  - A header whose data[1:0] != port_id is a misroute.
  - err_frame pulses.
  - Any partial packet is rolled back; the FSM goes to DROP and discards the packet through its trailer.
- When undefined: destination bits are not checked, and every header is accepted.

Test Plan:
- Reset, port_id=0; drive 10'b10_0000_0000, 01_0000_0000, 01_0000_0001, 11_0000_0010 with out_ready=1 → 4 entries out: sop on data 0x00, then 0x00, 0x01, eop on 0x02; first out_valid the cycle after the trailer; no errors.
- Short packets back-to-back (header 10_0001_0000, trailer 11_0001_1111, repeated 4×) with out_ready=0 → buffer holds 8 entries. Raise out_ready → 8 entries drain in order, sop/eop alternating.
- Framing:
  - 01_0000_0001 in IDLE → err_frame pulse, nothing stored.
  - Header, payload, then a second header 10_1001_0000, then trailer → err_frame once; only the second packet (2 entries) is delivered.
- Overflow, DEPTH=16, out_ready=0: send a 20-flit packet (header + 18 payload + trailer) → err_ovf pulses at the 17th flit, out_valid stays 0; a following 2-flit packet is delivered intact.
- Full with concurrent read: buffer holds 15 committed entries; send a 2-flit packet while out_ready=1 → the header is written (free=1), but the trailer in the next cycle sees free computed before that cycle's read. Checker verifies the err_ovf/commit outcome against the free formula.
- With SW_RX_DEST_CHK_EN, port_id=1: header 10_0000_0000 + trailer → err_frame, dropped; header 10_0000_0001 + trailer → delivered.
